// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Lock counter width; holds LOCK_MAX values up to 15.
  localparam int LOCK_CNT_W = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clr_load_reg.sv
// W-bit register with priority synchronous clear, load enable and load-zero select.
module clr_load_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load_en_i,
  input  logic         load_zero_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= '0;
    end else if (load_en_i) begin
      q_q <= load_zero_i ? '0 : d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N requesters write/clear access to one shared register.
// Optional per-owner write locking is enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            op_clr,
  input  logic [N*W-1:0]          wr_data,
`ifdef REG_ARB_LOCK_EN
  input  logic [N-1:0]            lock,
`endif
  output logic [N-1:0]            gnt,
  output logic [id_width(N)-1:0]  owner,
  output logic                    busy,
  output logic [W-1:0]            q
);

  localparam int ID_W = id_width(N);

  if (N < 2 || N > 8 || LOCK_MAX < 1 || LOCK_MAX > (2**LOCK_CNT_W - 1)) begin : g_bad_params
    $error("reg_write_arbiter: parameter out of range");
  end

  arb_state_e          state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic [ID_W:0]       pick_s;
  logic [ID_W-1:0]     ptr_next_s;
  logic                load_en_s;
  logic                load_zero_s;
  logic [W-1:0]        load_data_s;
`ifdef REG_ARB_LOCK_EN
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

  // Returns {found, index} of the first set request scanning upward from p, wrapping at N.
  function automatic logic [ID_W:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (r[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s      = pick(req, ptr_q);
  assign ptr_next_s  = (int'(owner_q) == N - 1) ? '0 : owner_q + ID_W'(1);
  assign load_zero_s = op_clr[owner_q];
  assign load_data_s = wr_data[int'(owner_q)*W +: W];

  // Next-state, grant and register-write decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    load_en_s = 1'b0;
`ifdef REG_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_s[ID_W]) begin
          state_d = ARB_OWN;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];
          owner_d = pick_s[ID_W-1:0];
          busy_d  = 1'b1;
`ifdef REG_ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ARB_OWN: begin
        load_en_s = 1'b1;
        state_d   = ARB_IDLE;
        gnt_d     = '0;
        busy_d    = 1'b0;
        ptr_d     = ptr_next_s;
`ifdef REG_ARB_LOCK_EN
        // Hold ownership while locked and this write is not the LOCK_MAX-th one.
        if (lock[owner_q] && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
          state_d    = ARB_OWN;
          gnt_d      = gnt_q;
          busy_d     = 1'b1;
          ptr_d      = ptr_q;
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Arbiter state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
`ifdef REG_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  clr_load_reg #(.W(W)) u_reg (
    .clk         (clk),
    .clear       (clear),
    .load_en_i   (load_en_s),
    .load_zero_i (load_zero_s),
    .d_i         (load_data_s),
    .q_o         (q)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one W-bit clearable register between N requesters. Each granted transaction either loads the requester's data word or clears the register. The block sits in front of the shared clearable-register datapath and is the only writer of it. Reset (`clear`) has priority over any write, matching the register's own synchronous clear.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8, any value (not restricted to powers of two).
- `W`, 8: register width.
- `LOCK_MAX`, 4: maximum consecutive locked writes per ownership. Used only with `REG_ARB_LOCK_EN`.

Ports:
- `clk`, input, 1: the single clock; all logic is posedge.
- `clear`, input, 1: synchronous, active-high reset.
- `req`, input, N: per-requester request; held high until the requester sees its `gnt` bit.
- `op_clr`, input, N: per-requester operation; 1 = clear register, 0 = load data.
- `wr_data`, input, N*W: requester i's data in bits [i*W +: W].
- `lock`, input, N: request to keep ownership. Present only with `REG_ARB_LOCK_EN`.
- `gnt`, output, N: registered, one-hot or zero.
- `owner`, output, $clog2(N): index of the current or last grantee.
- `busy`, output, 1: high while in OWN.
- `q`, output, W: shared register value.

## Operation
- FSM has two states, IDLE and OWN.
- **IDLE:** if any `req` bit is high at a posedge, select the winner.
  - Winner is the first i with `req[i]`=1, scanning from `ptr` upward modulo N.
  - Next state is OWN; `gnt[winner]` goes to 1 and `owner` is set to the winner.
- **OWN:** at the posedge that ends the grant cycle, the register updates from `owner`.
  - `op_clr[owner]`=1: q ← 0.
  - Otherwise: q ← `wr_data[owner]`.
  - Then `ptr` ← (owner+1) mod N, `gnt` ← 0, and the FSM returns to IDLE.
- The mandatory IDLE bubble keeps a requester that has not yet dropped `req` from being granted twice. Throughput is one write per 2 cycles.
- `req` from non-owners is ignored while in OWN. A requester that drops `req` before being granted is simply skipped (no error).
- **Reset:** `clear`=1 at a posedge sets state=IDLE, gnt=0, owner=0, ptr=0, busy=0, q=0.
  - This applies regardless of `req` or the state.
  - A write pending in that cycle is discarded.

## Timing
- Cycle 0: `req` is sampled high in IDLE.
- Cycle 1: `gnt`, `busy` and `owner` are valid. `wr_data` and `op_clr` of the owner are sampled at the end of this cycle.
- Cycle 2: `q` shows the new value and `gnt`=0.
- Latency from `req` to `q` is 2 edges.
- All outputs are registered; there are no combinational paths from input to output.
- `ptr` wraps from N-1 to 0. For N=3, the scan order after winner 2 is 0,1,2.

## Configuration
- `REG_ARB_LOCK_EN` defined:
  - If `lock[owner]`=1 at the end of a grant cycle and fewer than `LOCK_MAX` writes have been made in this ownership, the FSM stays in OWN with `gnt` held. The next write occurs the following cycle, giving back-to-back writes.
  - The `LOCK_MAX`-th write forces a return to IDLE, and `ptr` advances as normal.
  - The lock counter resets to 0 on `clear` and on each new ownership.
- `REG_ARB_LOCK_EN` undefined: the `lock` port and the counter are absent, and every ownership is exactly one write.

## Structure
- Package `reg_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_OWN`);
  - the ID-width function (clog2 with a minimum of 1);
  - the lock-counter width constant.
- Sub-module `clr_load_reg`: W-bit register with synchronous clear (priority), load enable and load-zero select. The arbiter instantiates it once for `q`.

## Test plan
- **Reset:** hold `clear`=1 for 3 cycles with `req`=4'b1111 → gnt=0, busy=0, q=0, owner=0 throughout; first grant after release is to requester 0.
- **Single write:** req[2]=1, wr_data[2]=8'hA5, op_clr=0 → gnt=4'b0100 in cycle 1 only; q=8'hA5 from cycle 2; busy 1 then 0.
- **Rotation:** all four `req` held continuously after reset → grants to 0,1,2,3,0 on cycles 1,3,5,7,9; gnt is never high on two consecutive cycles.
- **Clear op:** with q=8'hA5, req[1]=1, op_clr[1]=1, wr_data[1]=8'hFF → q=8'h00; ptr advances to 2.
- **Reset mid-grant:** assert `clear` during the cycle gnt[3]=1 with wr_data[3]=8'h3C → q=0 (not 8'h3C); gnt=0 on the next cycle; ptr=0.
- **Lock (REG_ARB_LOCK_EN, LOCK_MAX=4):** req[0]=lock[0]=1 with data 1,2,3,4,5 and req[3]=1 → q=1,2,3,4 on consecutive cycles; forced release after the 4th write; next grant is to 3; 5 is not written.
